// File: rtl/dsp_pkg.sv
// ----------------------------------------------------------------------------
// dsp_pkg
//   Shared constants and helpers for the FIR datapath blocks.
//   - DEF_* : default widths / tap count used as module parameter defaults.
//   - RS_W  : working width of the generic round/saturate helper. It must be
//             at least the widest accumulator any instantiation uses.
//   - acc_width() : full-precision accumulator width for a sum of `taps`
//             signed data_w x coef_w products (no intermediate overflow).
//   - round_sat() : round-half-up by 2^shift, then clamp to a signed
//             out_w-bit range. The result is returned sign-extended to RS_W.
// ----------------------------------------------------------------------------
package dsp_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_NUM_TAPS = 8;
  localparam int RS_W         = 64;

  function automatic int acc_width(input int data_w, input int coef_w,
                                   input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     shift,
    input int                     out_w
  );
    logic signed [RS_W-1:0] rounded;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    // Adding half an output LSB before the arithmetic shift gives
    // round-half-up (towards +inf on exact ties, also for negatives).
    if (shift > 0) begin
      rounded = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    end else begin
      rounded = acc;
    end
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (rounded > hi) begin
      return hi;
    end else if (rounded < lo) begin
      return lo;
    end else begin
      return rounded;
    end
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// ----------------------------------------------------------------------------
// fir_round_sat
//   Combinational round-half-up and saturation of a full-precision FIR
//   accumulator down to the output sample width.
//   Parameters:
//     ACC_W : accumulator width (must not exceed dsp_pkg::RS_W)
//     SHIFT : number of fractional bits dropped (COEF_W-2 for Q2.x coefs)
//     OUT_W : signed output width
//   Ports:
//     acc_i  : signed accumulator input
//     data_o : rounded, saturated signed output
// ----------------------------------------------------------------------------
module fir_round_sat
  import dsp_pkg::*;
#(
  parameter int ACC_W = 35,
  parameter int SHIFT = 14,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] data_o
);

  logic signed [RS_W-1:0] acc_ext;
  logic signed [RS_W-1:0] res_full;
  logic                   unused_res_hi;

  // Size cast of a signed operand sign-extends into the helper's width.
  assign acc_ext  = RS_W'(acc_i);
  assign res_full = round_sat(acc_ext, SHIFT, OUT_W);

  // After saturation the upper bits are pure sign extension.
  assign data_o        = res_full[OUT_W-1:0];
  assign unused_res_hi = ^res_full[RS_W-1:OUT_W];

endmodule

// File: rtl/interpolator_fir.sv
// ----------------------------------------------------------------------------
// interpolator_fir
//   Streaming direct-form FIR image-rejection filter placed after a 2x
//   zero-stuffing interpolator. One filtered, rounded, saturated sample is
//   produced per accepted input sample. Coefficients are Q2.(COEF_W-2) and
//   writable at run time; out of reset coef[0] is unity and the rest are
//   zero, so the block is a latency-2 passthrough.
//
//   Ports:
//     clk           : clock
//     arst_n        : asynchronous active-low reset
//     clr_in        : synchronous clear of delay line, products and valids
//     coef_we_in    : coefficient write strobe
//     coef_addr_in  : tap index to write (out-of-range writes are dropped)
//     coef_data_in  : signed coefficient value
//     src_valid_in  : upstream sample valid
//     src_data_in   : upstream signed sample
//     src_ready_out : block accepts a sample this cycle
//     dst_valid_out : filtered sample valid
//     dst_data_out  : filtered signed sample
//     dst_ready_in  : downstream ready
// ----------------------------------------------------------------------------
module interpolator_fir
  import dsp_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int COEF_W   = DEF_COEF_W
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          clr_in,
  input  logic                          coef_we_in,
  input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr_in,
  input  logic signed [COEF_W-1:0]      coef_data_in,
  input  logic                          src_valid_in,
  input  logic signed [DATA_W-1:0]      src_data_in,
  output logic                          src_ready_out,
  output logic                          dst_valid_out,
  output logic signed [DATA_W-1:0]      dst_data_out,
  input  logic                          dst_ready_in
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NUM_TAPS);
  localparam int SHIFT  = COEF_W - 2;
  localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(1 << (COEF_W - 2));

  // Coefficient bank.
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];

  // Delay line: the newest sample multiplies coef[0] directly from the input
  // port, so only NUM_TAPS-1 stored samples are ever needed.
  logic signed [DATA_W-1:0] tap_q  [NUM_TAPS-1];

  // Stage-1 products and valid.
  logic signed [PROD_W-1:0] prod_d    [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_p1_q [NUM_TAPS];
  logic                     vld_p1_q;

  // Stage-2 output registers.
  logic                     vld_p2_q;
  logic signed [DATA_W-1:0] data_p2_q;
  logic signed [DATA_W-1:0] data_p2_d;
  logic signed [ACC_W-1:0]  acc_p1;

  logic en;
  logic accept;
  logic coef_wr_ok;

  // The whole pipeline advances unless a valid output is being held back.
  // Ready is intentionally combinational from dst_ready_in.
  assign en            = ~(vld_p2_q & ~dst_ready_in);
  assign src_ready_out = en & ~clr_in;
  assign accept        = src_valid_in & src_ready_out;
  assign coef_wr_ok    = coef_we_in & (int'(coef_addr_in) < NUM_TAPS);

  assign dst_valid_out = vld_p2_q;
  assign dst_data_out  = data_p2_q;

  // --------------------------------------------------------------------------
  // Coefficient bank: writes are independent of the pipeline enable. A write
  // on the accept edge is seen by later samples only, because the products
  // below sample the current register contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_q[k] <= '0;
      end
      coef_q[0] <= COEF_UNITY;
    end else if (coef_wr_ok) begin
      coef_q[coef_addr_in] <= coef_data_in;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = '0;
    end
    prod_d[0] = PROD_W'(src_data_in) * PROD_W'(coef_q[0]);
    for (int k = 1; k < NUM_TAPS; k++) begin
      prod_d[k] = PROD_W'(tap_q[k-1]) * PROD_W'(coef_q[k]);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: delay-line shift and product capture on accept. Bubbles leave
  // the delay line and products untouched and only drop the valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < NUM_TAPS - 1; k++) begin
        tap_q[k] <= '0;
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod_p1_q[k] <= '0;
      end
      vld_p1_q <= 1'b0;
    end else if (clr_in) begin
      for (int k = 0; k < NUM_TAPS - 1; k++) begin
        tap_q[k] <= '0;
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod_p1_q[k] <= '0;
      end
      vld_p1_q <= 1'b0;
    end else if (en) begin
      if (accept) begin
        tap_q[0] <= src_data_in;
        for (int k = 1; k < NUM_TAPS - 1; k++) begin
          tap_q[k] <= tap_q[k-1];
        end
        for (int k = 0; k < NUM_TAPS; k++) begin
          prod_p1_q[k] <= prod_d[k];
        end
        vld_p1_q <= 1'b1;
      end else begin
        vld_p1_q <= 1'b0;
      end
    end
  end

  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc_p1 = acc_p1 + ACC_W'(prod_p1_q[k]);
    end
  end

  fir_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (DATA_W)
  ) u_round_sat (
    .acc_i  (acc_p1),
    .data_o (data_p2_d)
  );

  // --------------------------------------------------------------------------
  // Stage 2: full-precision sum, rounding and saturation into the output
  // register. A clear drops the valid but leaves the stale data in place.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else if (clr_in) begin
      vld_p2_q  <= 1'b0;
    end else if (en) begin
      vld_p2_q  <= vld_p1_q;
      data_p2_q <= data_p2_d;
    end
  end

endmodule
